multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Sequential HI/LO multiply unit; the execution-side counterpart that carries out the MULTU/MFHI/MFLO control the decoder emits.
- Accepts a start from the decoder with the two register operands (srca/srcb) and runs a radix-2 shift-add multiply over WIDTH cycles.
- Writes the 2*WIDTH product to architectural HI/LO and serves MFHI/MFLO reads.
- Raises stall to freeze the single-cycle datapath's PC and register writes while a result is pending.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start_mul  input  1  MULTU issued this cycle (decoder alucontrol 3'b100).
- start_div  input  1  DIVU issued this cycle; used only with MULTDIV_DIVU_EN.
- srca  input  WIDTH  first operand (rs); multiplicand or dividend.
- srcb  input  WIDTH  second operand (rt); multiplier or divisor.
- mfhi  input  1  MFHI issued this cycle.
- mflo  input  1  MFLO issued this cycle.
- busy  output  1  operation in progress.
- stall  output  1  datapath must hold the current instruction.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.
- hilo_out  output  WIDTH  read data for the register file: hi when mfhi, lo when mflo, 0 when neither.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, counter=0, all working registers cleared.
  - Outputs after reset: hi=0, lo=0, busy=0, stall=0.
  - Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- FSM states: IDLE and MUL; DIV exists only with MULTDIV_DIVU_EN.
- IDLE, start_mul=1:
  - Latch mcand=srca, acc={WIDTH'b0, srcb}, counter=0.
  - Go to MUL on the next edge.
  - start_mul has priority if start_div is also 1.
- MUL, each cycle:
  - s = acc_hi + (acc[0] ? mcand : 0), computed WIDTH+1 bits wide.
  - acc <= {s, acc_lo} >> 1 (carry shifts into the MSB).
  - counter increments.
- On the edge where counter==WIDTH-1:
  - hi<=upper half of the final acc, lo<=lower half.
  - state<=IDLE.
  - Exactly WIDTH cycles in MUL.
- Arithmetic is unsigned and exact; no overflow is possible, since the product fits 2*WIDTH bits.
- busy = (state != IDLE), registered state decode.
- Latency: start accepted at edge N; busy is high in cycles N+1..N+WIDTH. hi/lo hold the new value from cycle N+WIDTH+1 onward.
- stall = busy & (mfhi | mflo | start_mul | start_div), combinational.
  - A read or a new start issued while busy is held, not dropped.
  - Starts arriving while busy are ignored internally; the stalled instruction re-presents them after the unit returns to IDLE.
- hi/lo keep their old values for the whole operation; they update only at completion.
- hilo_out is combinational from the registered hi/lo. mfhi and mflo are never both 1; if they are, hi wins.
- Operands are sampled only on the accepting edge; later changes on srca/srcb have no effect.

Optional Feature:
- Macro: MULTDIV_DIVU_EN.
- Defined: adds state DIV, a WIDTH-cycle restoring division.
  - Each step: shift remainder left by 1, bringing in the next dividend MSB.
  - If rem >= divisor: subtract the divisor and set quotient bit = 1; otherwise quotient bit = 0.
  - At completion: lo=quotient, hi=remainder.
  - Divisor 0: result lo={WIDTH{1}}, hi=dividend, after the same WIDTH-cycle latency.
- Undefined: no DIV state and no divider logic. start_div is ignored but still contributes to stall while busy.

Decomposition:
- Shared package multdiv_pkg holds:
  - FSM state encoding: IDLE=2'd0, MUL=2'd1, DIV=2'd2.
  - Default WIDTH and CNTW values.
  - Decoder alucontrol constant ALU_MULTU=3'b100.
- One natural sub-module, multdiv_step: combinational single-iteration datapath.
  - Add-and-shift for MUL; compare-subtract-shift for DIV.
  - Instantiated once; the FSM, counter and registers stay in the top.

Test Plan:
- Simple product: srca=7, srcb=6, start_mul pulse → busy high exactly 32 cycles, then hi=0, lo=42.
- Full-scale product: srca=srcb=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001.
- Read during operation: mflo asserted 1 cycle after start_mul and held → stall=1 for 31 cycles; hilo_out = new lo on the first stall-free cycle; hi/lo keep prior values throughout.
- Reset mid-operation: reset low at cycle 10 of a multiply of 5*9 → next cycle busy=0, stall=0, hi=0, lo=0; a fresh 3*4 afterwards gives lo=12.
- Start while busy: start_mul with srca=2, srcb=2 while busy → stall=1, running result unaffected; reissue after IDLE gives lo=4.
- Division (MULTDIV_DIVU_EN only): 100/7 → lo=14, hi=2; 5/0 → lo=32'hFFFFFFFF, hi=5.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the HI/LO multiply (and optional divide) unit.
// The optional restoring divider is enabled by defining MULTDIV_DIVU_EN.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNTW_DEF  = 6;

    localparam logic [2:0] ALU_MULTU = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/multdiv_if.sv
// Decoder-facing bus of the multiply unit: start/read strobes, operands and HI/LO results.
interface multdiv_if #(parameter int WIDTH = multdiv_pkg::WIDTH_DEF);

    logic             start_mul;
    logic             start_div;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             mfhi;
    logic             mflo;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hilo_out;

    modport master (
        output start_mul, start_div, srca, srcb, mfhi, mflo,
        input  busy, stall, hi, lo, hilo_out
    );

    modport slave (
        input  start_mul, start_div, srca, srcb, mfhi, mflo,
        output busy, stall, hi, lo, hilo_out
    );

endinterface

// File: rtl/multdiv_step.sv
// One iteration of the multiply/divide datapath: add-and-shift right for MUL,
// and (with MULTDIV_DIVU_EN) compare-subtract-shift left for DIV.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
`ifdef MULTDIV_DIVU_EN
    input  logic               div_sel,
`endif
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH:0]   sum;

    assign acc_hi = acc_i[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_i[WIDTH-1:0];

`ifdef MULTDIV_DIVU_EN
    // acc holds {remainder, remaining dividend bits / quotient bits so far}.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_next;
    logic             ge;

    assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
    assign ge       = (shifted >= {1'b0, opnd_i});
    assign rem_next = ge ? (shifted[WIDTH-1:0] - opnd_i) : shifted[WIDTH-1:0];
`endif

    always_comb begin
        sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_i} : '0);
        acc_o = {sum, acc_lo[WIDTH-1:1]};
`ifdef MULTDIV_DIVU_EN
        if (div_sel) begin
            acc_o = {rem_next, acc_lo[WIDTH-2:0], ge};
        end
`endif
    end

endmodule

// File: rtl/multdiv_unit.sv
// Sequential HI/LO multiply unit driven by the decoder; stalls the core while busy.
// Define MULTDIV_DIVU_EN to add the WIDTH-cycle restoring DIVU path.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input logic     clk,
    input logic     reset,
    multdiv_if.slave bus
);

    state_e               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   step_acc;
    logic                 last;

    assign last = (cnt_q == CNTW'(WIDTH - 1));

    multdiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULTDIV_DIVU_EN
        .div_sel (state_q == DIV),
`endif
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .acc_o   (step_acc)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_mul) state_d = MUL;
`ifdef MULTDIV_DIVU_EN
                else if (bus.start_div) state_d = DIV;
`endif
            end
            default: if (last) state_d = IDLE;
        endcase
    end

    // NOTE: all working registers are cleared on reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (state_q == IDLE) begin
            if (bus.start_mul) begin
                opnd_d = bus.srca;
                acc_d  = {{WIDTH{1'b0}}, bus.srcb};
                cnt_d  = '0;
            end
`ifdef MULTDIV_DIVU_EN
            else if (bus.start_div) begin
                opnd_d = bus.srcb;
                acc_d  = {{WIDTH{1'b0}}, bus.srca};
                cnt_d  = '0;
            end
`endif
        end else begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNTW'(1);
            if (last) {hi_d, lo_d} = step_acc;
        end
    end

    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.stall    = bus.busy & (bus.mfhi | bus.mflo | bus.start_mul | bus.start_div);
        bus.hi       = hi_q;
        bus.lo       = lo_q;
        bus.hilo_out = bus.mfhi ? hi_q : (bus.mflo ? lo_q : '0);
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: product table, random products against a
// scoreboard, and hand-written stall / reset / re-issue sequences.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multdiv_if #(.WIDTH(W)) bus ();

    multdiv_unit #(.WIDTH(W), .CNTW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t             vecs[8];
    logic [2*W-1:0]   sb_q[$];
    logic [2*W-1:0]   last_exp;
    int               total = 0;
    int               bad   = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start_mul = 1'b1;
        bus.srca      = a;
        bus.srcb      = b;
        sb_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        @(posedge clk); #1;
        bus.start_mul = 1'b0;
        bus.srca      = W'($urandom);
        bus.srcb      = W'($urandom);
    endtask

`ifdef MULTDIV_DIVU_EN
    task automatic issue_div(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start_div = 1'b1;
        bus.srca      = a;
        bus.srcb      = b;
        if (b == '0) sb_q.push_back({a, {W{1'b1}}});
        else         sb_q.push_back({a % b, a / b});
        @(posedge clk); #1;
        bus.start_div = 1'b0;
        bus.srca      = W'($urandom);
        bus.srcb      = W'($urandom);
    endtask
`endif

    // Counts busy cycles, sampled on falling edges, until busy drops (bounded).
    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 4 * W) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pop_check(input string name);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got a completion, want none pending", name);
        end else begin
            last_exp = sb_q.pop_front();
            check(name, {bus.hi, bus.lo}, last_exp);
        end
    endtask

    task automatic check_reads(input string name);
        bus.mfhi = 1'b1; #1;
        check({name, "_mfhi"}, bus.hilo_out, last_exp[2*W-1:W]);
        bus.mflo = 1'b1; #1;
        check({name, "_both_hi_wins"}, bus.hilo_out, last_exp[2*W-1:W]);
        bus.mfhi = 1'b0; #1;
        check({name, "_mflo"}, bus.hilo_out, last_exp[W-1:0]);
        bus.mflo = 1'b0; #1;
        check({name, "_no_read"}, bus.hilo_out, '0);
    endtask

    task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        issue_mul(a, b);
        wait_done(n);
        check({name, "_busy_cycles"}, n, W);
        pop_check(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic [2*W-1:0] prev;

        vecs[0] = '{32'd7,         32'd6,         32'd0,         32'd42};
        vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'h00000001};
        vecs[2] = '{32'd0,         32'hDEADBEEF,  32'd0,         32'd0};
        vecs[3] = '{32'd1,         32'hFFFFFFFF,  32'd0,         32'hFFFFFFFF};
        vecs[4] = '{32'h00010000,  32'h00010000,  32'h00000001,  32'h00000000};
        vecs[5] = '{32'h80000000,  32'h80000000,  32'h40000000,  32'h00000000};
        vecs[6] = '{32'hFFFFFFFF,  32'd2,         32'h00000001,  32'hFFFFFFFE};
        vecs[7] = '{32'd3,         32'd5,         32'd0,         32'd15};

        reset         = 1'b0;
        bus.start_mul = 1'b0;
        bus.start_div = 1'b0;
        bus.srca      = '0;
        bus.srcb      = '0;
        bus.mfhi      = 1'b0;
        bus.mflo      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  bus.busy,  1'b0);
        check("reset_stall", bus.stall, 1'b0);
        check("reset_hilo",  {bus.hi, bus.lo}, '0);
        check("reset_out",   bus.hilo_out, '0);
        reset = 1'b1;

        // Table of products with hand-computed HI/LO.
        for (int i = 0; i < 8; i++) begin
            run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_table", i), {bus.hi, bus.lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            check_reads($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            run_mul($sformatf("rand%0d", i), W'($urandom), W'($urandom));
        end

        // start_mul wins over a simultaneous start_div.
        bus.start_div = 1'b1;
        issue_mul(32'd6, 32'd3);
        bus.start_div = 1'b0;
        wait_done(n);
        check("prio_busy_cycles", n, W);
        pop_check("prio_mul");

        // MFLO raised in the second busy cycle and held until the result is ready.
        prev = last_exp;
        issue_mul(32'h00012345, 32'h00006789);
        @(negedge clk);
        check("read_first_busy",  bus.busy,  1'b1);
        check("read_first_stall", bus.stall, 1'b0);
        @(posedge clk); #1;
        bus.mflo = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 4 * W) begin
            n++;
            check("read_stall", bus.stall, 1'b1);
            check("read_hilo_held", {bus.hi, bus.lo}, prev);
            @(negedge clk);
        end
        check("read_stall_cycles", n, W - 1);
        check("read_release", bus.stall, 1'b0);
        pop_check("read_result");
        check("read_hilo_out", bus.hilo_out, last_exp[W-1:0]);
        bus.mflo = 1'b0;

        // Reset in the tenth busy cycle of 5*9 aborts with no partial result.
        prev = last_exp;
        bus.start_mul = 1'b1;
        bus.srca      = 32'd5;
        bus.srcb      = 32'd9;
        @(posedge clk); #1;
        bus.start_mul = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy_before", bus.busy, 1'b1);
        check("abort_hilo_before", {bus.hi, bus.lo}, prev);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy",  bus.busy,  1'b0);
        check("abort_stall", bus.stall, 1'b0);
        check("abort_hilo",  {bus.hi, bus.lo}, '0);
        run_mul("after_abort", 32'd3, 32'd4);
        check("after_abort_lo", bus.lo, 32'd12);

        // New start while busy is stalled, then accepted once the unit is idle.
        issue_mul(32'h00001000, 32'd3);
        bus.start_mul = 1'b1;
        bus.srca      = 32'd2;
        bus.srcb      = 32'd2;
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 4 * W) begin
            n++;
            check("restart_stall", bus.stall, 1'b1);
            @(negedge clk);
        end
        check("restart_busy_cycles", n, W);
        pop_check("restart_first");
        check("restart_first_lo", bus.lo, 32'h00003000);
        check("restart_idle_stall", bus.stall, 1'b0);
        sb_q.push_back(64'd4);
        @(posedge clk); #1;
        bus.start_mul = 1'b0;
        wait_done(n);
        check("restart_second_busy", n, W);
        pop_check("restart_second");
        check("restart_second_lo", bus.lo, 32'd4);

`ifdef MULTDIV_DIVU_EN
        issue_div(32'd100, 32'd7);
        wait_done(n);
        check("div_busy_cycles", n, W);
        pop_check("div_100_7");
        check("div_100_7_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
        issue_div(32'd5, 32'd0);
        wait_done(n);
        check("div0_busy_cycles", n, W);
        pop_check("div_5_0");
        check("div_5_0_const", {bus.hi, bus.lo}, {32'd5, 32'hFFFFFFFF});
        for (int i = 0; i < 3; i++) begin
            issue_div(W'($urandom), W'($urandom_range(1, 1000)));
            wait_done(n);
            pop_check($sformatf("div_rand%0d", i));
        end
`endif

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d results left, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
